// File: rtl/can_ack_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : can_ack_responder                                               |
// | Purpose : Receive-side CAN frame tracker, CRC-15 checker, ACK responder   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module can_ack_responder #(
    parameter int EOF_BITS  = 7,
    parameter int IDLE_BITS = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_point,
    input  logic        tx_point,
    input  logic        rx_bit,
    input  logic        rx_stall,
    input  logic        self_tx,
    output logic        ack_tx,
    output logic        stuff_enable,
    output logic        busy,
    output logic        frame_ok,
    output logic        crc_error,
    output logic        form_error,
    output logic        ack_error,
    output logic [10:0] rx_id,
    output logic [3:0]  rx_dlc
);
    typedef enum logic [3:0] {
        ST_RECOVER      = 4'd0,
        ST_IDLE         = 4'd1,
        ST_ARB          = 4'd2,
        ST_CTRL         = 4'd3,
        ST_DATA         = 4'd4,
        ST_CRC          = 4'd5,
        ST_CRC_DEL      = 4'd6,
        ST_ACK_SLOT     = 4'd7,
        ST_ACK_DEL      = 4'd8,
        ST_EOF          = 4'd9,
        ST_INTERMISSION = 4'd10
    } state_t;

    localparam logic [14:0] CRC_POLY  = 15'h4599;
    localparam int          CNT_W     = 8;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_BITS - 1);
    localparam logic [CNT_W-1:0] EOF_LAST  = CNT_W'(EOF_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [14:0]      crc_q, crc_d;
    logic [10:0]      id_q, id_d;
    logic             rtr_q, rtr_d;
    logic [3:0]       dlc_q, dlc_d;
    logic [10:0]      rx_id_q, rx_id_d;
    logic [3:0]       rx_dlc_q, rx_dlc_d;
    logic             ack_tx_q, ack_tx_d;
    logic             ack_arm_q, ack_arm_d;
    logic             ack_rel_q, ack_rel_d;
    logic             stuff_q, stuff_d;
    logic             busy_q, busy_d;
    logic             ok_q, ok_d;
    logic             crc_err_q, crc_err_d;
    logic             form_err_q, form_err_d;
    logic             ack_err_q, ack_err_d;
    logic             start_frame, go_recover;

    logic             eff;
    logic [14:0]      crc_step;
    logic [3:0]       dlc_new;
    logic [3:0]       nbytes;
    logic [CNT_W-1:0] data_last;

    assign eff       = sample_point & ~rx_stall;
    assign crc_step  = {crc_q[13:0], 1'b0} ^ ((rx_bit ^ crc_q[14]) ? CRC_POLY : 15'd0);
    assign dlc_new   = {dlc_q[2:0], rx_bit};
    assign nbytes    = dlc_q[3] ? 4'd8 : dlc_q;
    assign data_last = {1'b0, nbytes, 3'b000} - 8'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        id_d        = id_q;
        rtr_d       = rtr_q;
        dlc_d       = dlc_q;
        rx_id_d     = rx_id_q;
        rx_dlc_d    = rx_dlc_q;
        ack_tx_d    = ack_tx_q;
        ack_arm_d   = ack_arm_q;
        ack_rel_d   = ack_rel_q;
        stuff_d     = stuff_q;
        ok_d        = 1'b0;
        crc_err_d   = 1'b0;
        form_err_d  = 1'b0;
        ack_err_d   = 1'b0;
        start_frame = 1'b0;
        go_recover  = 1'b0;

        // tx_point acts on the pre-edge arm/release flags only
        if (tx_point) begin
            if (ack_arm_q) begin
                ack_tx_d  = 1'b0;
                ack_arm_d = 1'b0;
            end else if (ack_rel_q) begin
                ack_tx_d  = 1'b1;
                ack_rel_d = 1'b0;
            end
        end

        if (eff) begin
            case (state_q)
                ST_RECOVER: begin
                    if (!rx_bit) begin
                        cnt_d = '0;
                    end else if (cnt_q == IDLE_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (!rx_bit) start_frame = 1'b1;
                end
                ST_ARB: begin
                    crc_d = crc_step;
                    if (cnt_q == 8'd11) begin
                        rtr_d   = rx_bit;
                        state_d = ST_CTRL;
                        cnt_d   = '0;
                    end else begin
                        id_d  = {id_q[9:0], rx_bit};
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_CTRL: begin
                    crc_d = crc_step;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd0 && rx_bit) begin
                        form_err_d = 1'b1;
                        go_recover = 1'b1;
                    end else if (cnt_q >= 8'd2) begin
                        dlc_d = dlc_new;
                        if (cnt_q == 8'd5) begin
                            state_d = (!rtr_q && dlc_new != 4'd0) ? ST_DATA : ST_CRC;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_DATA: begin
                    crc_d = crc_step;
                    if (cnt_q == data_last) begin
                        state_d = ST_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_CRC: begin
                    crc_d = crc_step;
                    if (cnt_q == 8'd14) begin
                        state_d = ST_CRC_DEL;
                        stuff_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_CRC_DEL: begin
                    if (!rx_bit) begin
                        form_err_d = 1'b1;
                        go_recover = 1'b1;
                    end else if (crc_q != 15'd0) begin
                        crc_err_d  = 1'b1;
                        go_recover = 1'b1;
                    end else begin
                        state_d   = ST_ACK_SLOT;
                        ack_arm_d = ~self_tx;
                    end
                end
                ST_ACK_SLOT: begin
                    if (self_tx && rx_bit) begin
                        ack_err_d  = 1'b1;
                        go_recover = 1'b1;
                    end else begin
                        state_d   = ST_ACK_DEL;
                        ack_rel_d = 1'b1;
                    end
                end
                ST_ACK_DEL: begin
                    if (!rx_bit) begin
                        form_err_d = 1'b1;
                        go_recover = 1'b1;
                    end else begin
                        state_d = ST_EOF;
                        cnt_d   = '0;
                    end
                end
                ST_EOF: begin
                    if (!rx_bit) begin
                        form_err_d = 1'b1;
                        go_recover = 1'b1;
                    end else if (cnt_q == EOF_LAST) begin
                        ok_d     = 1'b1;
                        rx_id_d  = id_q;
                        rx_dlc_d = dlc_q;
                        state_d  = ST_INTERMISSION;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_INTERMISSION: begin
                    // overload frames are not modelled; a dominant bit here starts a frame
                    if (!rx_bit) begin
                        start_frame = 1'b1;
                    end else if (cnt_q == 8'd2) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: go_recover = 1'b1;
            endcase
        end

        // SOF is dominant, so shifting it into a cleared register leaves zero
        if (start_frame) begin
            state_d = ST_ARB;
            cnt_d   = '0;
            crc_d   = '0;
            stuff_d = 1'b1;
        end

        if (go_recover) begin
            state_d   = ST_RECOVER;
            cnt_d     = '0;
            stuff_d   = 1'b0;
            ack_tx_d  = 1'b1;
            ack_arm_d = 1'b0;
            ack_rel_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_RECOVER);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RECOVER;
            cnt_q      <= '0;
            crc_q      <= '0;
            id_q       <= '0;
            rtr_q      <= 1'b0;
            dlc_q      <= '0;
            rx_id_q    <= '0;
            rx_dlc_q   <= '0;
            ack_tx_q   <= 1'b1;
            ack_arm_q  <= 1'b0;
            ack_rel_q  <= 1'b0;
            stuff_q    <= 1'b0;
            busy_q     <= 1'b0;
            ok_q       <= 1'b0;
            crc_err_q  <= 1'b0;
            form_err_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            id_q       <= id_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            rx_id_q    <= rx_id_d;
            rx_dlc_q   <= rx_dlc_d;
            ack_tx_q   <= ack_tx_d;
            ack_arm_q  <= ack_arm_d;
            ack_rel_q  <= ack_rel_d;
            stuff_q    <= stuff_d;
            busy_q     <= busy_d;
            ok_q       <= ok_d;
            crc_err_q  <= crc_err_d;
            form_err_q <= form_err_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign ack_tx       = ack_tx_q;
    assign stuff_enable = stuff_q;
    assign busy         = busy_q;
    assign frame_ok     = ok_q;
    assign crc_error    = crc_err_q;
    assign form_error   = form_err_q;
    assign ack_error    = ack_err_q;
    assign rx_id        = rx_id_q;
    assign rx_dlc       = rx_dlc_q;

endmodule
`default_nettype wire

// File: tb/tb_can_ack_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : tb_can_ack_responder                                            |
// | Purpose : Frame-level model and per-cycle checker for can_ack_responder   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_can_ack_responder;
    localparam int EOF_BITS  = 7;
    localparam int IDLE_BITS = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sample_point = 1'b0, tx_point = 1'b0, rx_stall = 1'b0, self_tx = 1'b0;
    logic drv_bit = 1'b1;
    logic rx_bit;
    logic ack_tx, stuff_enable, busy, frame_ok, crc_error, form_error, ack_error;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;

    // the bus is a wired-AND of the other nodes and our own ACK driver
    assign rx_bit = drv_bit & ack_tx;

    can_ack_responder #(.EOF_BITS(EOF_BITS), .IDLE_BITS(IDLE_BITS)) dut (
        .clk(clk), .rst(rst), .sample_point(sample_point), .tx_point(tx_point),
        .rx_bit(rx_bit), .rx_stall(rx_stall), .self_tx(self_tx),
        .ack_tx(ack_tx), .stuff_enable(stuff_enable), .busy(busy),
        .frame_ok(frame_ok), .crc_error(crc_error), .form_error(form_error),
        .ack_error(ack_error), .rx_id(rx_id), .rx_dlc(rx_dlc)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic chk_en = 1'b0;
    logic e_ack = 1'b1, e_stuff = 1'b0, e_busy = 1'b0;
    logic e_ok = 1'b0, e_crc = 1'b0, e_form = 1'b0, e_ackerr = 1'b0;
    logic [10:0] e_id = '0;
    logic [3:0]  e_dlc = '0;
    int ack_low_cycles = 0, ok_pulses = 0;

    logic fb[$];
    logic [10:0] f_id;
    logic [3:0]  f_dlc;
    int i_crc_end, i_delim, i_ack, i_ackdel, i_eof_end, i_im_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("ack_tx", {31'd0, ack_tx}, {31'd0, e_ack});
            check("stuff_enable", {31'd0, stuff_enable}, {31'd0, e_stuff});
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("frame_ok", {31'd0, frame_ok}, {31'd0, e_ok});
            check("crc_error", {31'd0, crc_error}, {31'd0, e_crc});
            check("form_error", {31'd0, form_error}, {31'd0, e_form});
            check("ack_error", {31'd0, ack_error}, {31'd0, e_ackerr});
            check("rx_id", {21'd0, rx_id}, {21'd0, e_id});
            check("rx_dlc", {28'd0, rx_dlc}, {28'd0, e_dlc});
            if (ack_tx === 1'b0) ack_low_cycles++;
            if (frame_ok === 1'b1) ok_pulses++;
        end
    end

    // CRC as the remainder of M(x)*x^15 divided by x^15 + 0x4599
    function automatic logic [14:0] crc_div(input logic m[$]);
        logic r[$];
        logic [15:0] g;
        logic [14:0] c;
        g = 16'hC599;
        r = m;
        for (int k = 0; k < 15; k++) r.push_back(1'b0);
        for (int i = 0; i < m.size(); i++)
            if (r[i]) for (int j = 0; j < 16; j++) r[i+j] = r[i+j] ^ g[15-j];
        for (int k = 0; k < 15; k++) c[14-k] = r[m.size()+k];
        return c;
    endfunction

    task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                         input logic [63:0] data, input logic flip0,
                         input logic ack_lvl, input logic ackdel_lvl);
        int nb;
        logic [14:0] c;
        f_id = id;
        f_dlc = dlc;
        fb.delete();
        fb.push_back(1'b0);
        for (int k = 10; k >= 0; k--) fb.push_back(id[k]);
        fb.push_back(rtr);
        fb.push_back(1'b0);
        fb.push_back(1'b0);
        for (int k = 3; k >= 0; k--) fb.push_back(dlc[k]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int k = 0; k < 8*nb; k++) fb.push_back(data[63-k]);
        c = crc_div(fb);
        c[0] = c[0] ^ flip0;
        for (int k = 14; k >= 0; k--) fb.push_back(c[k]);
        i_crc_end = fb.size() - 1;
        fb.push_back(1'b1);
        fb.push_back(ack_lvl);
        fb.push_back(ackdel_lvl);
        for (int k = 0; k < EOF_BITS + 3; k++) fb.push_back(1'b1);
        i_delim   = i_crc_end + 1;
        i_ack     = i_crc_end + 2;
        i_ackdel  = i_crc_end + 3;
        i_eof_end = i_ackdel + EOF_BITS;
        i_im_end  = i_eof_end + 3;
    endtask

    task automatic tx_phase(input logic b, input logic upd_ack, input logic ack_val);
        @(negedge clk);
        tx_point = 1'b1;
        drv_bit  = b;
        if (upd_ack) e_ack = ack_val;
        @(negedge clk);
        tx_point = 1'b0;
        @(negedge clk);
    endtask

    task automatic sample_begin(input logic stall);
        @(negedge clk);
        sample_point = 1'b1;
        rx_stall     = stall;
    endtask

    task automatic sample_end();
        @(negedge clk);
        sample_point = 1'b0;
        rx_stall     = 1'b0;
        e_ok = 1'b0; e_crc = 1'b0; e_form = 1'b0; e_ackerr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_recessive(input int n);
        for (int k = 0; k < n; k++) begin
            tx_phase(1'b1, 1'b0, 1'b0);
            sample_begin(1'b0);
            sample_end();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tx_point = 1'b0; sample_point = 1'b0; rx_stall = 1'b0; drv_bit = 1'b1;
        e_ack = 1'b1; e_stuff = 1'b0; e_busy = 1'b0;
        e_ok = 1'b0; e_crc = 1'b0; e_form = 1'b0; e_ackerr = 1'b0;
        e_id = '0; e_dlc = '0;
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives the frame in fb and predicts outputs from the frame layout
    task automatic run_frame(input logic self, input logic [127:0] stuff_mask,
                             input int abort_at, input logic flip0);
        logic ack_exp, b, ended;
        self_tx = self;
        ack_exp = !self && !flip0;
        ended   = 1'b0;
        for (int i = 0; i < fb.size() && !ended; i++) begin
            if (stuff_mask[i]) begin
                tx_phase(1'b0, 1'b0, 1'b0);
                sample_begin(1'b1);
                sample_end();
            end
            if (i == i_ack && ack_exp)         tx_phase(fb[i], 1'b1, 1'b0);
            else if (i == i_ackdel && ack_exp) tx_phase(fb[i], 1'b1, 1'b1);
            else                               tx_phase(fb[i], 1'b0, 1'b0);
            if (i == abort_at) begin
                do_reset();
                ended = 1'b1;
                check("mid_rst_ack_tx", {31'd0, ack_tx}, 32'd1);
                check("mid_rst_busy", {31'd0, busy}, 32'd0);
                check("mid_rst_rx_id", {21'd0, rx_id}, 32'd0);
            end else begin
                sample_begin(1'b0);
                b = (i == i_ack && ack_exp) ? 1'b0 : fb[i];
                if (i == 0) begin e_busy = 1'b1; e_stuff = 1'b1; end
                if (i == i_crc_end) e_stuff = 1'b0;
                if (i == i_delim && flip0) begin e_crc = 1'b1; ended = 1'b1; end
                if (i == i_ack && self && b) begin e_ackerr = 1'b1; ended = 1'b1; end
                if (i == i_ackdel && !b) begin e_form = 1'b1; ended = 1'b1; end
                if (i == i_eof_end) begin e_ok = 1'b1; e_id = f_id; e_dlc = f_dlc; end
                if (i == i_im_end) e_busy = 1'b0;
                if (ended) begin e_busy = 1'b0; e_stuff = 1'b0; e_ack = 1'b1; end
                sample_end();
            end
        end
        self_tx = 1'b0;
        if (ended) send_recessive(IDLE_BITS);
    endtask

    initial begin
        logic pq[$];
        logic [127:0] smask;

        pq.push_back(1'b1);
        check("crc_pin_1", {17'd0, crc_div(pq)}, 32'h4599);
        pq.push_back(1'b0);
        check("crc_pin_10", {17'd0, crc_div(pq)}, 32'h4EAB);

        do_reset();
        check("reset_ack_tx", {31'd0, ack_tx}, 32'd1);
        check("reset_rx_dlc", {28'd0, rx_dlc}, 32'd0);

        // ten recessive samples are one short of bus integration
        send_recessive(10);
        tx_phase(1'b0, 1'b0, 1'b0);
        sample_begin(1'b0);
        sample_end();
        check("sof_ignored_busy", {31'd0, busy}, 32'd0);
        send_recessive(IDLE_BITS);

        build(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        check("frame_len", fb.size(), 32'd63);
        check("crc_end_idx", i_crc_end, 32'd49);
        ack_low_cycles = 0; ok_pulses = 0;
        run_frame(1'b0, '0, -1, 1'b0);
        check("A_ack_low_cycles", ack_low_cycles, 32'd8);
        check("A_ok_pulses", ok_pulses, 32'd1);
        check("A_rx_id", {21'd0, rx_id}, 32'h123);
        check("A_rx_dlc", {28'd0, rx_dlc}, 32'd2);

        build(11'h7A5, 1'b0, 4'd3, 64'hDEAD_BE00_0000_0000, 1'b1, 1'b1, 1'b1);
        ack_low_cycles = 0; ok_pulses = 0;
        run_frame(1'b0, '0, -1, 1'b1);
        check("B_ack_low_cycles", ack_low_cycles, 32'd0);
        check("B_ok_pulses", ok_pulses, 32'd0);
        check("B_rx_id_kept", {21'd0, rx_id}, 32'h123);

        // remote frame sent by us, acknowledged by another node
        build(11'h3FF, 1'b1, 4'd9, 64'd0, 1'b0, 1'b0, 1'b1);
        ack_low_cycles = 0;
        run_frame(1'b1, '0, -1, 1'b0);
        check("E_ack_low_cycles", ack_low_cycles, 32'd0);
        check("E_rx_dlc", {28'd0, rx_dlc}, 32'd9);

        build(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        smask = '0;
        smask[5] = 1'b1; smask[14] = 1'b1; smask[22] = 1'b1; smask[33] = 1'b1; smask[45] = 1'b1;
        ok_pulses = 0;
        run_frame(1'b0, smask, -1, 1'b0);
        check("C_ok_pulses", ok_pulses, 32'd1);
        check("C_rx_id", {21'd0, rx_id}, 32'h123);

        build(11'h001, 1'b0, 4'd1, 64'hFF00_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        ack_low_cycles = 0;
        run_frame(1'b1, '0, -1, 1'b0);
        check("F_ack_low_cycles", ack_low_cycles, 32'd0);

        build(11'h400, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        run_frame(1'b0, '0, -1, 1'b0);
        check("G_rx_id_kept", {21'd0, rx_id}, 32'h123);

        build(11'h7FF, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 1'b1);
        run_frame(1'b0, '0, -1, 1'b0);
        check("H_rx_id", {21'd0, rx_id}, 32'h7FF);
        check("H_rx_dlc", {28'd0, rx_dlc}, 32'd15);

        build(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        run_frame(1'b0, '0, 25, 1'b0);
        run_frame(1'b0, '0, i_ack, 1'b0);
        ok_pulses = 0;
        run_frame(1'b0, '0, -1, 1'b0);
        check("final_ok_pulses", ok_pulses, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
